// File: rtl/seven_seg_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM state
// encodings, default timing constants and a counter-width helper.
package seven_seg_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DWELL = 2'd3
   } arb_state_t;

   localparam int CLK_HZ                 = 50_000_000;
   localparam int DEFAULT_DWELL_CYCLES   = CLK_HZ;   // one second of dwell
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request searching upward
// from (last + 1) mod NUM_REQ with wrap-around.
module rr_arbiter
   import seven_seg_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = cnt_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   logic [IDX_W-1:0] idx;

   // NOTE: every output and temporary gets a default first so no latch is inferred.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = IDX_W'((int'(last) + off) % NUM_REQ);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter sharing one seven-segment display engine among NUM_REQ
// requesters with a post-write dwell. Macro SEVEN_SEG_ARB_TIMEOUT_EN adds a BUSY timeout.
module seven_seg_arbiter
   import seven_seg_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DWELL_CYCLES   = DEFAULT_DWELL_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [32*NUM_REQ-1:0]      req_data,
   input  logic [NUM_REQ-1:0]         req_base,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [NUM_REQ-1:0]         req_err,
   output logic [31:0]                seg_data,
   output logic                       seg_base,
   output logic                       seg_wen,
   input  logic                       seg_rdy,
   input  logic                       seg_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int DW_W  = cnt_width(DWELL_CYCLES);
   localparam logic [DW_W-1:0] DWELL_LOAD =
      DW_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

   arb_state_t         state_q, state_d;
   logic [IDX_W-1:0]   last_q;
   logic [DW_W-1:0]    dwell_cnt;
   logic [NUM_REQ-1:0] rr_grant;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_any;
   logic               grant_take;
   logic               done_take;
   logic               timeout_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .last      (last_q),
      .grant     (rr_grant),
      .grant_idx (rr_idx),
      .any       (rr_any)
   );

   always_comb begin
      state_d    = state_q;
      grant_take = 1'b0;
      done_take  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rr_any && seg_rdy) begin
               grant_take = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_BUSY;
         ST_BUSY: begin
            // A done in the timeout cycle still wins and acks normally.
            if (seg_done) begin
               done_take = 1'b1;
               state_d   = (DWELL_CYCLES == 0) ? ST_IDLE : ST_DWELL;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_DWELL: begin
            if (dwell_cnt == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: every control and datapath register is async-reset so a reset
   // mid-transaction leaves no stale grant, strobe or pending ack behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         last_q    <= IDX_W'(NUM_REQ - 1);
         seg_data  <= '0;
         seg_base  <= 1'b0;
         grant_id  <= '0;
         req_ack   <= '0;
         dwell_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         req_ack <= done_take ? (NUM_REQ'(1) << grant_id) : '0;
         if (grant_take) begin
            seg_data <= req_data[32*rr_idx +: 32];
            seg_base <= |(req_base & rr_grant);
            grant_id <= rr_idx;
            last_q   <= rr_idx;
         end
         if (done_take)
            dwell_cnt <= DWELL_LOAD;
         else if (state_q == ST_DWELL && dwell_cnt != '0)
            dwell_cnt <= dwell_cnt - DW_W'(1);
      end
   end

   assign seg_wen = (state_q == ST_ISSUE);
   assign busy    = (state_q != ST_IDLE);

`ifdef SEVEN_SEG_ARB_TIMEOUT_EN
   localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0]    busy_cnt;
   logic [NUM_REQ-1:0] err_q;

   // busy_cnt counts completed BUSY cycles; the last one fires the timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= '0;
         err_q    <= '0;
      end else begin
         if (state_q != ST_BUSY)
            busy_cnt <= '0;
         else if (busy_cnt != TO_LAST)
            busy_cnt <= busy_cnt + TO_W'(1);
         err_q <= (timeout_hit && !seg_done) ? (NUM_REQ'(1) << grant_id) : '0;
      end
   end

   assign timeout_hit = (state_q == ST_BUSY) && (busy_cnt == TO_LAST);
   assign req_err     = err_q;
`else
   assign timeout_hit = 1'b0;
   assign req_err     = '0;
`endif

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Scoreboard bench for seven_seg_arbiter with a display-engine stub of
// programmable done latency. Define SEVEN_SEG_ARB_TIMEOUT_EN to add the timeout test.
module tb_seven_seg_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DWELL   = 4;
   localparam int TMO     = 16;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      logic        base;
   } wr_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [32*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_base;
   logic [NUM_REQ-1:0]   req_ack;
   logic [NUM_REQ-1:0]   req_err;
   logic [31:0]          seg_data;
   logic                 seg_base;
   logic                 seg_wen;
   logic                 seg_rdy;
   logic                 seg_done;
   logic [1:0]           grant_id;
   logic                 busy;

   logic rdy_en;
   logic stub_busy;
   assign seg_rdy = rdy_en & ~stub_busy;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int ack_count = 0, err_count = 0, wen_count = 0;
   int last_ack_cyc = 0, last_err_cyc = 0, last_done_cyc = 0;
   int stub_default = 2;
   logic [NUM_REQ-1:0] auto_drop;

   wr_t wr_q[$];
   int  ack_q[$];
   int  err_q[$];
   int  lat_q[$];
   int  wen_hist[$];

   seven_seg_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DWELL_CYCLES   (DWELL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_base  (req_base),
      .req_ack   (req_ack),
      .req_err   (req_err),
      .seg_data  (seg_data),
      .seg_base  (seg_base),
      .seg_wen   (seg_wen),
      .seg_rdy   (seg_rdy),
      .seg_done  (seg_done),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every write, ack and err.
   initial begin
      wr_t e;
      int  id;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (seg_wen) begin
               wen_count++;
               wen_hist.push_back(cyc);
               n_vec++;
               if (wr_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_wen: id=%0d data=%h, required no write", grant_id, seg_data);
               end else begin
                  e = wr_q.pop_front();
                  if ({grant_id, seg_data, seg_base} !== {e.id, e.data, e.base}) begin
                     n_err++;
                     $display("FAIL write: id=%0d data=%h base=%b, required id=%0d data=%h base=%b",
                              grant_id, seg_data, seg_base, e.id, e.data, e.base);
                  end
               end
            end
            if (req_ack !== '0) begin
               ack_count++;
               last_ack_cyc = cyc;
               req_valid = req_valid & ~(req_ack & auto_drop);
               n_vec++;
               if (ack_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_ack: req_ack=%b, required 0000", req_ack);
               end else begin
                  id = ack_q.pop_front();
                  if (req_ack !== (4'b0001 << id)) begin
                     n_err++;
                     $display("FAIL ack: req_ack=%b, required %b", req_ack, 4'b0001 << id);
                  end
               end
            end
            if (req_err !== '0) begin
               err_count++;
               last_err_cyc = cyc;
               req_valid = req_valid & ~(req_err & auto_drop);
               n_vec++;
               if (err_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_err: req_err=%b, required 0000", req_err);
               end else begin
                  id = err_q.pop_front();
                  if (req_err !== (4'b0001 << id)) begin
                     n_err++;
                     $display("FAIL err: req_err=%b, required %b", req_err, 4'b0001 << id);
                  end
               end
            end
         end
      end
   end

   // Display engine stub: done pulses 'latency' cycles after the write; 0 = never.
   initial begin
      int cnt;
      int lat;
      cnt       = 0;
      seg_done  = 1'b0;
      stub_busy = 1'b0;
      forever begin
         @(negedge clk);
         seg_done = 1'b0;
         if (!rst_n) begin
            cnt       = 0;
            stub_busy = 1'b0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  seg_done      = 1'b1;
                  stub_busy     = 1'b0;
                  last_done_cyc = cyc;
               end
            end
            if (seg_wen) begin
               lat = (lat_q.size() > 0) ? lat_q.pop_front() : stub_default;
               if (lat > 0) begin
                  cnt       = lat;
                  stub_busy = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int count_of(input int kind);
      case (kind)
         0:       return ack_count;
         1:       return wen_count;
         default: return err_count;
      endcase
   endfunction

   task automatic wait_events(input int kind, input int target, input int budget, input string what);
      int k = 0;
      while (count_of(kind) < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (count_of(kind) < target) begin
         n_err++;
         $display("FAIL %s: %0d events seen, required %0d within %0d cycles",
                  what, count_of(kind), target, budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      auto_drop = '1;
      rdy_en    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int a0, e0;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5678};
      req_base  = 4'b1111;
      auto_drop = '1;
      rdy_en    = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({req_ack, req_err, seg_wen, seg_base, busy, grant_id} !== '0) begin
         n_err++;
         $display("FAIL reset_ctrl: ack=%b err=%b wen=%b base=%b busy=%b id=%0d, required all 0",
                  req_ack, req_err, seg_wen, seg_base, busy, grant_id);
      end
      n_vec++;
      if (seg_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_data: seg_data=%h, required 00000000", seg_data);
      end
      // Release with only requester 0 pending, then reset it mid-BUSY.
      req_valid = 4'b0001;
      lat_q.push_back(30);
      wr_q.push_back('{id: 2'd0, data: 32'h1234_5678, base: 1'b1});
      a0 = ack_count;
      e0 = err_count;
      rst_n = 1'b1;
      wait_events(1, wen_count + 1, 10, "reset_first_grant");
      repeat (3) @(negedge clk);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_busy_pre: busy=%b, required 1", busy);
      end
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      n_vec++;
      if ({busy, seg_wen, seg_data} !== '0) begin
         n_err++;
         $display("FAIL reset_async: busy=%b wen=%b data=%h, required all 0", busy, seg_wen, seg_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      n_vec++;
      if (ack_count != a0 || err_count != e0) begin
         n_err++;
         $display("FAIL reset_abandon: %0d acks %0d errs after reset, required 0 0",
                  ack_count - a0, err_count - e0);
      end
   endtask

   task automatic test_single();
      int w0, a0, idle_cyc;
      do_reset();
      req_data[63:32] = 32'h00AB_CDEF;
      req_base[1]     = 1'b0;
      wr_q.push_back('{id: 2'd1, data: 32'h00AB_CDEF, base: 1'b0});
      ack_q.push_back(1);
      w0 = wen_count;
      a0 = ack_count;
      req_valid[1] = 1'b1;
      wait_events(0, a0 + 1, 30, "single_ack");
      idle_cyc = -1;
      for (int k = 0; k < 20 && idle_cyc < 0; k++) begin
         if (!busy) idle_cyc = cyc;
         else @(negedge clk);
      end
      n_vec++;
      if (wen_count - w0 != 1) begin
         n_err++;
         $display("FAIL single_wen_count: %0d strobes, required 1", wen_count - w0);
      end
      n_vec++;
      if (last_done_cyc - wen_hist[wen_hist.size()-1] != 2 || last_ack_cyc - last_done_cyc != 1) begin
         n_err++;
         $display("FAIL single_latency: wen->done %0d done->ack %0d, required 2 and 1",
                  last_done_cyc - wen_hist[wen_hist.size()-1], last_ack_cyc - last_done_cyc);
      end
      n_vec++;
      if (idle_cyc - last_ack_cyc != DWELL) begin
         n_err++;
         $display("FAIL single_dwell: ack->idle %0d cycles, required %0d", idle_cyc - last_ack_cyc, DWELL);
      end
      n_vec++;
      if ({grant_id, seg_data} !== {2'd1, 32'h00AB_CDEF}) begin
         n_err++;
         $display("FAIL single_hold: id=%0d data=%h, required id=1 data=00abcdef", grant_id, seg_data);
      end
   endtask

   task automatic test_fairness();
      int a0;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = 32'h1000_0000 + i;
      req_base = 4'b0101;
      for (int r = 0; r < 5; r++) begin
         wr_q.push_back('{id: 2'(r % 4), data: 32'h1000_0000 + (r % 4), base: ((r % 4) % 2 == 0)});
         ack_q.push_back(r % 4);
      end
      a0 = ack_count;
      auto_drop = '0;
      req_valid = 4'b1111;
      wait_events(0, a0 + 5, 200, "fair_acks");
      req_valid = '0;
      auto_drop = '1;
      repeat (20) @(negedge clk);
      n_vec++;
      if (wr_q.size() != 0 || ack_q.size() != 0) begin
         n_err++;
         $display("FAIL fair_drain: %0d writes %0d acks pending, required 0 0", wr_q.size(), ack_q.size());
      end
   endtask

   task automatic test_rdy_low();
      int hi;
      do_reset();
      rdy_en          = 1'b0;
      req_data[31:0]  = 32'hCAFE_0001;
      req_base[0]     = 1'b1;
      wr_q.push_back('{id: 2'd0, data: 32'hCAFE_0001, base: 1'b1});
      ack_q.push_back(0);
      req_valid[0] = 1'b1;
      hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (seg_wen || busy) hi++;
      end
      n_vec++;
      if (hi != 0) begin
         n_err++;
         $display("FAIL rdy_hold: %0d active cycles with seg_rdy low, required 0", hi);
      end
      rdy_en = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({seg_wen, grant_id} !== {1'b1, 2'd0}) begin
         n_err++;
         $display("FAIL rdy_grant: wen=%b id=%0d one cycle after seg_rdy, required wen=1 id=0", seg_wen, grant_id);
      end
      wait_events(0, ack_count + 1, 30, "rdy_ack");
   endtask

   task automatic test_withdraw();
      int w0, a0;
      do_reset();
      req_data[31:0] = 32'h0000_0A0A;
      req_base[0]    = 1'b0;
      req_data[95:64] = 32'hDEAD_BEEF;
      wr_q.push_back('{id: 2'd0, data: 32'h0000_0A0A, base: 1'b0});
      ack_q.push_back(0);
      req_valid[0] = 1'b1;
      wait_events(0, ack_count + 1, 30, "withdraw_first_ack");
      @(negedge clk);
      req_valid[2] = 1'b1;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL withdraw_in_dwell: busy=%b during pulse, required 1", busy);
      end
      @(negedge clk);
      req_valid[2] = 1'b0;
      w0 = wen_count;
      a0 = ack_count;
      repeat (15) @(negedge clk);
      n_vec++;
      if (wen_count != w0 || ack_count != a0) begin
         n_err++;
         $display("FAIL withdraw: %0d writes %0d acks after withdrawal, required 0 0",
                  wen_count - w0, ack_count - a0);
      end
   endtask

   task automatic test_decimal();
      int a0, low;
      do_reset();
      lat_q.push_back(40);
      req_data[127:96] = 32'd123456;
      req_base[3]      = 1'b1;
      wr_q.push_back('{id: 2'd3, data: 32'd123456, base: 1'b1});
      ack_q.push_back(3);
      a0 = ack_count;
      req_valid[3] = 1'b1;
      wait_events(1, wen_count + 1, 10, "dec_write");
      low = 0;
      for (int k = 0; k < 60 && ack_count == a0; k++) begin
         if (!busy) low++;
         @(negedge clk);
      end
      wait_events(0, a0 + 1, 1, "dec_ack");
      n_vec++;
      if (low != 0) begin
         n_err++;
         $display("FAIL dec_busy: busy low for %0d cycles, required 0", low);
      end
      n_vec++;
      if (last_done_cyc - wen_hist[wen_hist.size()-1] != 40 || last_ack_cyc - last_done_cyc != 1) begin
         n_err++;
         $display("FAIL dec_latency: wen->done %0d done->ack %0d, required 40 and 1",
                  last_done_cyc - wen_hist[wen_hist.size()-1], last_ack_cyc - last_done_cyc);
      end
      n_vec++;
      if (seg_base !== 1'b1) begin
         n_err++;
         $display("FAIL dec_base: seg_base=%b, required 1", seg_base);
      end
   endtask

   task automatic test_back_to_back();
      int h0;
      do_reset();
      req_data[63:32] = 32'h0000_1111;
      req_data[95:64] = 32'h0000_2222;
      req_base[2:1]   = 2'b10;
      wr_q.push_back('{id: 2'd1, data: 32'h0000_1111, base: 1'b0});
      wr_q.push_back('{id: 2'd2, data: 32'h0000_2222, base: 1'b1});
      ack_q.push_back(1);
      ack_q.push_back(2);
      h0 = wen_hist.size();
      req_valid[2:1] = 2'b11;
      wait_events(0, ack_count + 2, 60, "b2b_acks");
      n_vec++;
      if (wen_hist.size() - h0 != 2) begin
         n_err++;
         $display("FAIL b2b_writes: %0d writes, required 2", wen_hist.size() - h0);
      end else if (wen_hist[h0+1] - wen_hist[h0] != 2 + 2 + DWELL) begin
         n_err++;
         $display("FAIL b2b_gap: %0d cycles between writes, required %0d",
                  wen_hist[h0+1] - wen_hist[h0], 2 + 2 + DWELL);
      end
   endtask

`ifdef SEVEN_SEG_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int h0, a0;
      do_reset();
      lat_q.push_back(0);
      req_data[31:0]  = 32'h0BAD_0000;
      req_data[63:32] = 32'h600D_0001;
      req_base[1:0]   = 2'b00;
      wr_q.push_back('{id: 2'd0, data: 32'h0BAD_0000, base: 1'b0});
      wr_q.push_back('{id: 2'd1, data: 32'h600D_0001, base: 1'b0});
      err_q.push_back(0);
      ack_q.push_back(1);
      h0 = wen_hist.size();
      a0 = ack_count;
      req_valid[1:0] = 2'b11;
      wait_events(2, err_count + 1, 40, "tmo_err");
      wait_events(0, a0 + 1, 40, "tmo_next_ack");
      n_vec++;
      if (wen_hist.size() - h0 != 2) begin
         n_err++;
         $display("FAIL tmo_writes: %0d writes, required 2", wen_hist.size() - h0);
      end else if (last_err_cyc - wen_hist[h0] != TMO + 1 || wen_hist[h0+1] - last_err_cyc != 1) begin
         n_err++;
         $display("FAIL tmo_timing: wen->err %0d err->next wen %0d, required %0d and 1",
                  last_err_cyc - wen_hist[h0], wen_hist[h0+1] - last_err_cyc, TMO + 1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_rdy_low();
      test_withdraw();
      test_decimal();
      test_back_to_back();
`ifdef SEVEN_SEG_ARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (5) @(negedge clk);
      n_vec++;
      if (wr_q.size() != 0 || ack_q.size() != 0 || err_q.size() != 0) begin
         n_err++;
         $display("FAIL final_drain: %0d writes %0d acks %0d errs outstanding, required 0 0 0",
                  wr_q.size(), ack_q.size(), err_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
